// File: rtl/key_sched_ctrl.sv
// Sequencer for round-key expansion: accepts a cipher key, drives the first/main
// expansion stages under a timeout, and arbitrates cipher access to the key RAMs.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no schedule present, waiting for a key
// WAIT_CIPHER | new key accepted, waiting for cipher to release key RAM
// LOAD        | one-cycle key load pulse into the expansion datapath
// FIRST       | first-round-key stage running (start pulse on entry)
// MAIN        | main round-key stage writing the key RAMs
// READY       | schedule valid, cipher may be granted the key RAM
// ERR         | bad configuration or stage timeout
module key_sched_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic [3:0]   iCfg_KC,
  input  logic [3:0]   iCfg_BC,
  input  logic         iKey_valid,
  output logic         oKey_ready,
  input  logic [127:0] iKey_data,
  output logic         oKey_load,
  output logic [31:0]  oKey_data_1,
  output logic [31:0]  oKey_data_2,
  output logic [31:0]  oKey_data_3,
  output logic [31:0]  oKey_data_4,
  output logic [3:0]   oRound,
  output logic         oFirst_start,
  input  logic         iFirst_done,
  input  logic         iMain_done,
  output logic         oAbort,
  input  logic         iCipher_req,
  output logic         oCipher_grant,
  input  logic         iCipher_done,
  output logic         oSched_valid,
  output logic         oBusy,
  output logic         oError,
  output logic [7:0]   oKey_gen
);

  typedef enum logic [2:0] {
    IDLE, WAIT_CIPHER, LOAD, FIRST, MAIN, READY, ERR
  } state_t;

  state_t       state, state_nxt;
  logic         hs, cfg_ok, tmo_hit, timeout, in_wait;
  logic [3:0]   kc_max;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic [CNT_W-1:0] cnt;
  logic         first_start_q, abort_q, grant_q, sched_valid_q, error_q;
  logic [7:0]   gen_q;

  always_comb begin
    oKey_ready = (state == IDLE) || (state == READY) || (state == ERR);
    hs         = iKey_valid && oKey_ready;
    cfg_ok     = ((iCfg_KC == 4'd4) || (iCfg_KC == 4'd6) || (iCfg_KC == 4'd8)) &&
                 ((iCfg_BC == 4'd4) || (iCfg_BC == 4'd6) || (iCfg_BC == 4'd8));
    kc_max     = (iCfg_KC > iCfg_BC) ? iCfg_KC : iCfg_BC;
    in_wait    = (state == FIRST) || (state == MAIN);
    // The counter reaches the limit at the edge closing this cycle; a done
    // arriving in this same cycle still wins.
    tmo_hit    = in_wait && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (hs) state_nxt = cfg_ok ? LOAD : ERR;
      end
      READY: begin
        if (hs) begin
          if (!cfg_ok)                         state_nxt = ERR;
          else if (grant_q && !iCipher_done)   state_nxt = WAIT_CIPHER;
          else                                 state_nxt = LOAD;
        end
      end
      WAIT_CIPHER: if (iCipher_done) state_nxt = LOAD;
      LOAD:        state_nxt = FIRST;
      FIRST: begin
        if (iFirst_done)  state_nxt = MAIN;
        else if (tmo_hit) begin
          state_nxt = ERR;
          timeout   = 1'b1;
        end
      end
      MAIN: begin
        if (iMain_done)   state_nxt = READY;
        else if (tmo_hit) begin
          state_nxt = ERR;
          timeout   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state         <= IDLE;
      key_q         <= '0;
      round_q       <= '0;
      cnt           <= '0;
      first_start_q <= 1'b0;
      abort_q       <= 1'b0;
      grant_q       <= 1'b0;
      sched_valid_q <= 1'b0;
      error_q       <= 1'b0;
      gen_q         <= '0;
    end else begin
      state         <= state_nxt;
      first_start_q <= (state == LOAD);
      abort_q       <= timeout;

      if (state_nxt != state) cnt <= '0;
      else if (in_wait)       cnt <= cnt + CNT_W'(1);

      if (hs) begin
        key_q   <= iKey_data;
        round_q <= kc_max + 4'd6;
        error_q <= !cfg_ok;
      end else if (timeout) begin
        error_q <= 1'b1;
      end

      if (state == MAIN && iMain_done) gen_q <= gen_q + 8'd1;

      // A rekey that must wait for the cipher keeps the old schedule visible.
      if (state == MAIN && iMain_done)                     sched_valid_q <= 1'b1;
      else if (timeout)                                    sched_valid_q <= 1'b0;
      else if (hs && state_nxt != WAIT_CIPHER)             sched_valid_q <= 1'b0;
      else if (state == WAIT_CIPHER && state_nxt == LOAD)  sched_valid_q <= 1'b0;

      if (grant_q) begin
        if (iCipher_done) grant_q <= 1'b0;
      end else if (state == READY && sched_valid_q && iCipher_req && !hs) begin
        grant_q <= 1'b1;
      end
    end
  end

  assign oKey_load     = (state == LOAD);
  assign oBusy         = (state == LOAD) || (state == FIRST) || (state == MAIN);
  assign oFirst_start  = first_start_q;
  assign oAbort        = abort_q;
  assign oCipher_grant = grant_q;
  assign oSched_valid  = sched_valid_q;
  assign oError        = error_q;
  assign oKey_gen      = gen_q;
  assign oRound        = round_q;
  assign oKey_data_1   = key_q[127:96];
  assign oKey_data_2   = key_q[95:64];
  assign oKey_data_3   = key_q[63:32];
  assign oKey_data_4   = key_q[31:0];

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with a 16-cycle timeout; expectations are
// hand-derived cycle by cycle from the controller's behaviour.
module tb_key_sched_ctrl;

  logic         iClk, iRst_n;
  logic [3:0]   iCfg_KC, iCfg_BC;
  logic         iKey_valid, oKey_ready;
  logic [127:0] iKey_data;
  logic         oKey_load;
  logic [31:0]  oKey_data_1, oKey_data_2, oKey_data_3, oKey_data_4;
  logic [3:0]   oRound;
  logic         oFirst_start, iFirst_done, iMain_done, oAbort;
  logic         iCipher_req, oCipher_grant, iCipher_done;
  logic         oSched_valid, oBusy, oError;
  logic [7:0]   oKey_gen;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KEY_A = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
  localparam logic [127:0] KEY_B = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] KEY_C = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [127:0] KEY_D = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  key_sched_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(10)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iCfg_KC(iCfg_KC), .iCfg_BC(iCfg_BC),
    .iKey_valid(iKey_valid), .oKey_ready(oKey_ready), .iKey_data(iKey_data),
    .oKey_load(oKey_load), .oKey_data_1(oKey_data_1), .oKey_data_2(oKey_data_2),
    .oKey_data_3(oKey_data_3), .oKey_data_4(oKey_data_4), .oRound(oRound),
    .oFirst_start(oFirst_start), .iFirst_done(iFirst_done), .iMain_done(iMain_done),
    .oAbort(oAbort), .iCipher_req(iCipher_req), .oCipher_grant(oCipher_grant),
    .iCipher_done(iCipher_done), .oSched_valid(oSched_valid), .oBusy(oBusy),
    .oError(oError), .oKey_gen(oKey_gen)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Presents a key for exactly one edge; afterwards the DUT shows the post-handshake state.
  task automatic offer(input logic [3:0] kc, input logic [3:0] bc, input logic [127:0] key);
    iCfg_KC = kc; iCfg_BC = bc; iKey_data = key; iKey_valid = 1'b1;
    tick();
    iKey_valid = 1'b0;
  endtask

  // From LOAD: FIRST, done immediately, MAIN, done immediately, READY.
  task automatic finish_sched();
    tick();
    iFirst_done = 1'b1; tick(); iFirst_done = 1'b0;
    iMain_done  = 1'b1; tick(); iMain_done  = 1'b0;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; tick(); tick();
    n_checks++; if ({oKey_ready,oKey_load,oFirst_start,oAbort,oCipher_grant,oSched_valid,oBusy,oError} !== 8'b1000_0000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 10000000", {oKey_ready,oKey_load,oFirst_start,oAbort,oCipher_grant,oSched_valid,oBusy,oError}); end
    n_checks++; if ({oKey_gen,oRound,oKey_data_1,oKey_data_2,oKey_data_3,oKey_data_4} !== 140'd0) begin n_fail++; $display("FAIL reset_data: gen=%0d round=%0d key1=%h want all 0", oKey_gen, oRound, oKey_data_1); end
    iRst_n = 1'b1; tick();
    n_checks++; if ({oKey_ready,oBusy} !== 2'b10) begin n_fail++; $display("FAIL reset_idle: ready/busy=%b want 10", {oKey_ready,oBusy}); end
  endtask

  task automatic test_nominal();
    offer(4'd4, 4'd4, KEY_A);
    n_checks++; if ({oKey_load,oBusy,oKey_ready,oFirst_start} !== 4'b1100) begin n_fail++; $display("FAIL nom_load: load/busy/ready/start=%b want 1100", {oKey_load,oBusy,oKey_ready,oFirst_start}); end
    n_checks++; if (oRound !== 4'd10) begin n_fail++; $display("FAIL nom_round: got %0d want 10", oRound); end
    n_checks++; if ({oKey_data_1,oKey_data_2,oKey_data_3,oKey_data_4} !== KEY_A) begin n_fail++; $display("FAIL nom_key: got %h %h %h %h want %h", oKey_data_1, oKey_data_2, oKey_data_3, oKey_data_4, KEY_A); end
    tick();
    n_checks++; if ({oKey_load,oFirst_start} !== 2'b01) begin n_fail++; $display("FAIL nom_start: load/start=%b want 01", {oKey_load,oFirst_start}); end
    iMain_done = 1'b1; tick(); iMain_done = 1'b0;
    n_checks++; if ({oFirst_start,oBusy} !== 2'b01) begin n_fail++; $display("FAIL nom_start_once: start/busy=%b want 01", {oFirst_start,oBusy}); end
    repeat (3) tick();
    iFirst_done = 1'b1; tick(); iFirst_done = 1'b0;
    repeat (12) tick();
    n_checks++; if ({oSched_valid,oBusy} !== 2'b01) begin n_fail++; $display("FAIL nom_main: valid/busy=%b want 01", {oSched_valid,oBusy}); end
    iMain_done = 1'b1; tick(); iMain_done = 1'b0;
    n_checks++; if ({oSched_valid,oBusy,oKey_ready,oError} !== 4'b1010) begin n_fail++; $display("FAIL nom_ready: valid/busy/ready/err=%b want 1010", {oSched_valid,oBusy,oKey_ready,oError}); end
    n_checks++; if (oKey_gen !== 8'd1) begin n_fail++; $display("FAIL nom_gen: got %0d want 1", oKey_gen); end
  endtask

  task automatic test_done_at_limit();
    offer(4'd6, 4'd4, KEY_B);
    n_checks++; if ({oRound,oSched_valid} !== {4'd12,1'b0}) begin n_fail++; $display("FAIL lim_load: round=%0d valid=%b want 12 0", oRound, oSched_valid); end
    tick();
    iFirst_done = 1'b1; tick(); iFirst_done = 1'b0;
    repeat (15) tick();
    n_checks++; if ({oBusy,oError} !== 2'b10) begin n_fail++; $display("FAIL lim_c15: busy/err=%b want 10", {oBusy,oError}); end
    iMain_done = 1'b1; tick(); iMain_done = 1'b0;
    n_checks++; if ({oSched_valid,oError,oAbort,oKey_gen} !== {3'b100,8'd2}) begin n_fail++; $display("FAIL lim_done: valid/err/abort=%b gen=%0d want 100 2", {oSched_valid,oError,oAbort}, oKey_gen); end
  endtask

  task automatic test_bad_config();
    offer(4'd5, 4'd4, KEY_C);
    n_checks++; if ({oError,oKey_load,oSched_valid,oKey_ready,oBusy} !== 5'b10010) begin n_fail++; $display("FAIL bad_err: err/load/valid/ready/busy=%b want 10010", {oError,oKey_load,oSched_valid,oKey_ready,oBusy}); end
    tick();
    n_checks++; if ({oError,oKey_load} !== 2'b10) begin n_fail++; $display("FAIL bad_sticky: err/load=%b want 10", {oError,oKey_load}); end
    offer(4'd8, 4'd6, KEY_C);
    n_checks++; if ({oError,oKey_load,oRound} !== {2'b01,4'd14}) begin n_fail++; $display("FAIL bad_recover: err/load=%b round=%0d want 01 14", {oError,oKey_load}, oRound); end
    finish_sched();
    n_checks++; if ({oSched_valid,oKey_gen} !== {1'b1,8'd3}) begin n_fail++; $display("FAIL bad_done: valid=%b gen=%0d want 1 3", oSched_valid, oKey_gen); end
  endtask

  task automatic test_timeout();
    offer(4'd4, 4'd4, KEY_D);
    tick();
    iFirst_done = 1'b1; tick(); iFirst_done = 1'b0;
    repeat (15) tick();
    n_checks++; if ({oBusy,oError,oAbort} !== 3'b100) begin n_fail++; $display("FAIL tmo_c15: busy/err/abort=%b want 100", {oBusy,oError,oAbort}); end
    tick();
    n_checks++; if ({oError,oAbort,oSched_valid,oBusy,oKey_ready} !== 5'b11001) begin n_fail++; $display("FAIL tmo_err: err/abort/valid/busy/ready=%b want 11001", {oError,oAbort,oSched_valid,oBusy,oKey_ready}); end
    n_checks++; if (oKey_gen !== 8'd3) begin n_fail++; $display("FAIL tmo_gen: got %0d want 3", oKey_gen); end
    tick();
    n_checks++; if ({oAbort,oError} !== 2'b01) begin n_fail++; $display("FAIL tmo_pulse: abort/err=%b want 01", {oAbort,oError}); end
    iMain_done = 1'b1; tick(); iMain_done = 1'b0;
    n_checks++; if ({oSched_valid,oKey_gen} !== {1'b0,8'd3}) begin n_fail++; $display("FAIL tmo_late_done: valid=%b gen=%0d want 0 3", oSched_valid, oKey_gen); end
  endtask

  task automatic test_rekey_grant();
    offer(4'd4, 4'd4, KEY_A);
    finish_sched();
    iCipher_req = 1'b1; tick();
    n_checks++; if ({oCipher_grant,oKey_gen} !== {1'b1,8'd4}) begin n_fail++; $display("FAIL rk_grant: grant=%b gen=%0d want 1 4", oCipher_grant, oKey_gen); end
    offer(4'd4, 4'd8, KEY_B);
    n_checks++; if ({oKey_load,oSched_valid,oCipher_grant,oKey_ready,oBusy} !== 5'b01100) begin n_fail++; $display("FAIL rk_wait: load/valid/grant/ready/busy=%b want 01100", {oKey_load,oSched_valid,oCipher_grant,oKey_ready,oBusy}); end
    n_checks++; if ({oRound,oKey_data_1} !== {4'd14,32'h00112233}) begin n_fail++; $display("FAIL rk_latch: round=%0d key1=%h want 14 00112233", oRound, oKey_data_1); end
    repeat (3) tick();
    n_checks++; if ({oKey_load,oCipher_grant} !== 2'b01) begin n_fail++; $display("FAIL rk_hold: load/grant=%b want 01", {oKey_load,oCipher_grant}); end
    iCipher_done = 1'b1; iCipher_req = 1'b0; tick(); iCipher_done = 1'b0;
    n_checks++; if ({oKey_load,oCipher_grant,oSched_valid} !== 3'b100) begin n_fail++; $display("FAIL rk_release: load/grant/valid=%b want 100", {oKey_load,oCipher_grant,oSched_valid}); end
    finish_sched();
    n_checks++; if ({oSched_valid,oKey_gen} !== {1'b1,8'd5}) begin n_fail++; $display("FAIL rk_done: valid=%b gen=%0d want 1 5", oSched_valid, oKey_gen); end
  endtask

  task automatic test_collision();
    iCipher_req = 1'b1;
    offer(4'd4, 4'd6, KEY_C);
    n_checks++; if ({oCipher_grant,oKey_load,oRound} !== {2'b01,4'd12}) begin n_fail++; $display("FAIL col_load: grant/load=%b round=%0d want 01 12", {oCipher_grant,oKey_load}, oRound); end
    tick();
    iFirst_done = 1'b1; tick(); iFirst_done = 1'b0;
    n_checks++; if ({oCipher_grant,oBusy} !== 2'b01) begin n_fail++; $display("FAIL col_busy: grant/busy=%b want 01", {oCipher_grant,oBusy}); end
    iMain_done = 1'b1; tick(); iMain_done = 1'b0;
    n_checks++; if ({oCipher_grant,oSched_valid} !== 2'b01) begin n_fail++; $display("FAIL col_ready: grant/valid=%b want 01", {oCipher_grant,oSched_valid}); end
    tick();
    n_checks++; if (oCipher_grant !== 1'b1) begin n_fail++; $display("FAIL col_grant: got %b want 1", oCipher_grant); end
    iCipher_req = 1'b0; iCipher_done = 1'b1; tick(); iCipher_done = 1'b0;
    n_checks++; if ({oCipher_grant,oKey_gen} !== {1'b0,8'd6}) begin n_fail++; $display("FAIL col_drop: grant=%b gen=%0d want 0 6", oCipher_grant, oKey_gen); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 249; i++) begin
      offer(4'd4, 4'd4, {4{32'(i)}});
      finish_sched();
    end
    n_checks++; if (oKey_gen !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", oKey_gen); end
    offer(4'd8, 4'd8, KEY_D);
    finish_sched();
    n_checks++; if ({oKey_gen,oRound,oSched_valid} !== {8'd0,4'd14,1'b1}) begin n_fail++; $display("FAIL wrap_0: gen=%0d round=%0d valid=%b want 0 14 1", oKey_gen, oRound, oSched_valid); end
  endtask

  task automatic test_reset_mid();
    offer(4'd4, 4'd4, KEY_A);
    tick();
    n_checks++; if ({oFirst_start,oBusy} !== 2'b11) begin n_fail++; $display("FAIL rst_first: start/busy=%b want 11", {oFirst_start,oBusy}); end
    iRst_n = 1'b0; tick();
    n_checks++; if ({oKey_ready,oKey_load,oFirst_start,oAbort,oCipher_grant,oSched_valid,oBusy,oError} !== 8'b1000_0000) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 10000000", {oKey_ready,oKey_load,oFirst_start,oAbort,oCipher_grant,oSched_valid,oBusy,oError}); end
    n_checks++; if ({oKey_gen,oRound,oKey_data_1,oKey_data_2,oKey_data_3,oKey_data_4} !== 140'd0) begin n_fail++; $display("FAIL rst_mid_data: gen=%0d round=%0d key1=%h want all 0", oKey_gen, oRound, oKey_data_1); end
    iRst_n = 1'b1; tick();
    n_checks++; if ({oAbort,oKey_ready,oBusy} !== 3'b010) begin n_fail++; $display("FAIL rst_after: abort/ready/busy=%b want 010", {oAbort,oKey_ready,oBusy}); end
  endtask

  initial begin
    iRst_n = 1'b0; iCfg_KC = '0; iCfg_BC = '0; iKey_valid = 1'b0; iKey_data = '0;
    iFirst_done = 1'b0; iMain_done = 1'b0; iCipher_req = 1'b0; iCipher_done = 1'b0;
    test_reset();
    test_nominal();
    test_done_at_limit();
    test_bad_config();
    test_timeout();
    test_rekey_grant();
    test_collision();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
